// File: rtl/cpu6502_pkg.sv
// Shared 6502 core definitions: interrupt vectors, sequencer state and
// interrupt-kind encodings.
package cpu6502_pkg;

    localparam logic [7:0] VEC_NMI = 8'hFA;
    localparam logic [7:0] VEC_RST = 8'hFC;
    localparam logic [7:0] VEC_IRQ = 8'hFE;

    typedef enum logic [1:0] {
        ST_RST = 2'd0,
        ST_RUN = 2'd1,
        ST_INT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        KIND_NMI = 2'd0,
        KIND_IRQ = 2'd1,
        KIND_BRK = 2'd2
    } int_kind_t;

endpackage

// File: rtl/irq_sequencer_if.sv
// Handshake between the instruction decoder (master) and the interrupt
// sequencer (slave).
interface irq_sequencer_if;

    logic       READY;
    logic       sync;
    logic       p_i;
    logic       brk_op;
    logic       vec_fetch;
    logic       vec_done;
    logic       force_brk;
    logic       ipc_inhibit;
    logic       rw_inhibit;
    logic [7:0] vec_adl;
    logic       b_flag;
    logic       nmi_pend;

    modport master (
        output READY, sync, p_i, brk_op, vec_fetch, vec_done,
        input  force_brk, ipc_inhibit, rw_inhibit, vec_adl, b_flag, nmi_pend
    );

    modport slave (
        input  READY, sync, p_i, brk_op, vec_fetch, vec_done,
        output force_brk, ipc_inhibit, rw_inhibit, vec_adl, b_flag, nmi_pend
    );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous pin; reset value selectable so
// active-low pins can come out of reset in their idle (high) state.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic r_ff1;
    logic r_ff2;

    // shift the pin through two flops, free-running regardless of READY
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ff1 <= RST_VAL;
            r_ff2 <= RST_VAL;
        end else begin
            r_ff1 <= i_d;
            r_ff2 <= r_ff1;
        end
    end

    assign o_q = r_ff2;

endmodule

// File: rtl/irq_sequencer.sv
// 6502 interrupt sequencer: synchronizes NMI/IRQ, latches NMI edges and
// steers the decoder through reset, IRQ, NMI and BRK vector sequences.
//
// state  | meaning
// -------+-----------------------------------------------------------
// ST_RST | reset sequence: forced BRK, stack writes inhibited, $FFFC
// ST_RUN | normal execution, interrupts sampled at sync
// ST_INT | servicing IRQ/NMI/BRK until the vector is loaded
module irq_sequencer
    import cpu6502_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            NMI,
    input  logic            IRQ,
    irq_sequencer_if.slave  bus
);

    state_t    r_state;
    state_t    w_state_next;
    int_kind_t r_int_kind;
    logic      r_nmi_pend;
    logic      r_nmi_hist;

    logic      w_nmi_s;
    logic      w_irq_s;
    logic      w_nmi_fall;
    logic      w_irq_req;
    logic      w_boundary;
    logic      w_take_int;
    logic      w_take_brk;
    logic      w_nmi_clear;

    sync2 #(.RST_VAL(1'b1)) u_sync_nmi (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (NMI),
        .o_q   (w_nmi_s)
    );

    sync2 #(.RST_VAL(1'b1)) u_sync_irq (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   (IRQ),
        .o_q   (w_irq_s)
    );

    assign w_nmi_fall  = r_nmi_hist & ~w_nmi_s;
    assign w_irq_req   = ~w_irq_s & ~bus.p_i;
    assign w_boundary  = (r_state == ST_RUN) & bus.sync & bus.READY;
    assign w_take_int  = w_boundary & (r_nmi_pend | w_irq_req);
    assign w_take_brk  = w_boundary & bus.brk_op & ~(r_nmi_pend | w_irq_req);
    // the $FFFA fetch is what consumes a pending NMI
    assign w_nmi_clear = bus.READY & (r_state == ST_INT) & bus.vec_fetch & r_nmi_pend;

    // edge history keeps running while READY is low so no NMI edge is missed
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_nmi_hist <= 1'b1;
        end else begin
            r_nmi_hist <= w_nmi_s;
        end
    end

    // NMI pending latch; a new edge wins over the clear in the same cycle
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_nmi_pend <= 1'b0;
        end else if (w_nmi_fall) begin
            r_nmi_pend <= 1'b1;
        end else if (w_nmi_clear) begin
            r_nmi_pend <= 1'b0;
        end
    end

    // record which service was started at the instruction boundary
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_int_kind <= KIND_IRQ;
        end else if (w_take_int) begin
            r_int_kind <= r_nmi_pend ? KIND_NMI : KIND_IRQ;
        end else if (w_take_brk) begin
            r_int_kind <= KIND_BRK;
        end
    end

    // state register, frozen while the core is stalled
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RST;
        end else if (bus.READY) begin
            r_state <= w_state_next;
        end
    end

    // next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RST: begin
                if (bus.vec_done) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_take_int || w_take_brk) begin
                    w_state_next = ST_INT;
                end
            end
            ST_INT: begin
                if (bus.vec_done) begin
                    w_state_next = ST_RUN;
                end
            end
            default: begin
                w_state_next = ST_RST;
            end
        endcase
    end

    // output decode; interrupt entry forces BRK in the sync cycle itself
    always_comb begin
        bus.force_brk   = 1'b0;
        bus.ipc_inhibit = 1'b0;
        bus.rw_inhibit  = 1'b0;
        bus.b_flag      = 1'b0;
        bus.vec_adl     = VEC_IRQ;
        case (r_state)
            ST_RST: begin
                bus.force_brk   = 1'b1;
                bus.ipc_inhibit = 1'b1;
                bus.rw_inhibit  = 1'b1;
                bus.vec_adl     = VEC_RST;
            end
            ST_RUN: begin
                bus.force_brk   = w_take_int;
                bus.ipc_inhibit = w_take_int;
            end
            ST_INT: begin
                bus.force_brk   = (r_int_kind != KIND_BRK);
                bus.ipc_inhibit = (r_int_kind != KIND_BRK);
                bus.b_flag      = (r_int_kind == KIND_BRK);
                bus.vec_adl     = r_nmi_pend ? VEC_NMI : VEC_IRQ;
            end
            default: begin
                bus.force_brk   = 1'b1;
                bus.ipc_inhibit = 1'b1;
                bus.rw_inhibit  = 1'b1;
                bus.vec_adl     = VEC_RST;
            end
        endcase
    end

    assign bus.nmi_pend = r_nmi_pend;

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: directed scenarios followed by random stimulus,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_irq_sequencer;

    logic i_clk;
    logic i_rst;
    logic NMI;
    logic IRQ;

    irq_sequencer_if bus();

    irq_sequencer dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .NMI   (NMI),
        .IRQ   (IRQ),
        .bus   (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // pin sample histories, index 0 = most recently clocked sample
    int nq[3];
    int iq[3];
    int m_mode;   // 0 reset sequence, 1 running, 2 servicing
    int m_kind;   // 0 NMI, 1 IRQ, 2 BRK
    int m_pend;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            nq[i] = 1;
            iq[i] = 1;
        end
        m_mode = 0;
        m_kind = 1;
        m_pend = 0;
    endfunction

    function automatic int irq_wanted();
        return (iq[1] == 0 && bus.p_i == 1'b0) ? 1 : 0;
    endfunction

    function automatic void model_step();
        int fall;
        int clr;
        if (i_rst) begin
            model_reset();
            return;
        end
        fall = (nq[2] == 1 && nq[1] == 0) ? 1 : 0;
        clr  = 0;
        if (bus.READY) begin
            if (m_mode == 0) begin
                if (bus.vec_done) m_mode = 1;
            end else if (m_mode == 1) begin
                if (bus.sync) begin
                    if (m_pend == 1 || irq_wanted() == 1) begin
                        m_mode = 2;
                        m_kind = (m_pend == 1) ? 0 : 1;
                    end else if (bus.brk_op) begin
                        m_mode = 2;
                        m_kind = 2;
                    end
                end
            end else begin
                if (bus.vec_fetch && m_pend == 1) clr = 1;
                if (bus.vec_done) m_mode = 1;
            end
        end
        if (fall == 1) m_pend = 1;
        else if (clr == 1) m_pend = 0;
        nq[2] = nq[1]; nq[1] = nq[0]; nq[0] = int'(NMI);
        iq[2] = iq[1]; iq[1] = iq[0]; iq[0] = int'(IRQ);
    endfunction

    task automatic model_compare();
        int e_fb, e_ipc, e_rw, e_b, e_vec;
        e_fb = 0; e_ipc = 0; e_rw = 0; e_b = 0; e_vec = 'hFE;
        if (m_mode == 0) begin
            e_fb = 1; e_ipc = 1; e_rw = 1; e_vec = 'hFC;
        end else if (m_mode == 1) begin
            if (bus.sync && bus.READY && (m_pend == 1 || irq_wanted() == 1)) begin
                e_fb = 1; e_ipc = 1;
            end
        end else begin
            e_fb  = (m_kind != 2) ? 1 : 0;
            e_ipc = e_fb;
            e_b   = (m_kind == 2) ? 1 : 0;
            e_vec = (m_pend == 1) ? 'hFA : 'hFE;
        end
        chk("m_force_brk",   32'(bus.force_brk),   32'(e_fb));
        chk("m_ipc_inhibit", 32'(bus.ipc_inhibit), 32'(e_ipc));
        chk("m_rw_inhibit",  32'(bus.rw_inhibit),  32'(e_rw));
        chk("m_b_flag",      32'(bus.b_flag),      32'(e_b));
        chk("m_vec_adl",     32'(bus.vec_adl),     32'(e_vec));
        chk("m_nmi_pend",    32'(bus.nmi_pend),    32'(m_pend));
    endtask

    // inputs are already applied on the falling edge when this is called
    task automatic tick();
        #1;
        model_compare();
        @(posedge i_clk);
        model_step();
        @(negedge i_clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic idle_inputs();
        bus.READY = 1'b1; bus.sync = 1'b0; bus.brk_op = 1'b0;
        bus.vec_fetch = 1'b0; bus.vec_done = 1'b0;
    endtask

    initial begin
        model_reset();
        i_rst = 1'b1; NMI = 1'b1; IRQ = 1'b1; bus.p_i = 1'b1;
        idle_inputs();
        @(negedge i_clk);

        // reset sequence
        i_rst = 1'b1;
        #1;
        chk("rst_force_brk", 32'(bus.force_brk), 32'd1);
        chk("rst_nmi_pend",  32'(bus.nmi_pend),  32'd0);
        chk("rst_b_flag",    32'(bus.b_flag),    32'd0);
        ticks(2);
        i_rst = 1'b0; bus.vec_fetch = 1'b1;
        #1;
        chk("rst_vec_adl",    32'(bus.vec_adl),    32'hFC);
        chk("rst_rw_inhibit", 32'(bus.rw_inhibit), 32'd1);
        tick();
        bus.vec_fetch = 1'b0; bus.vec_done = 1'b1;
        tick();
        idle_inputs();
        #1;
        chk("run_force_brk",   32'(bus.force_brk),   32'd0);
        chk("run_ipc_inhibit", 32'(bus.ipc_inhibit), 32'd0);
        chk("run_rw_inhibit",  32'(bus.rw_inhibit),  32'd0);
        chk("run_vec_adl",     32'(bus.vec_adl),     32'hFE);
        tick();

        // IRQ unmasked
        IRQ = 1'b0; bus.p_i = 1'b0;
        ticks(3);
        bus.sync = 1'b1;
        #1;
        chk("irq_sync_force_brk", 32'(bus.force_brk),   32'd1);
        chk("irq_sync_ipc",       32'(bus.ipc_inhibit), 32'd1);
        tick();
        bus.sync = 1'b0;
        tick();
        bus.vec_fetch = 1'b1;
        #1;
        chk("irq_vec_adl", 32'(bus.vec_adl), 32'hFE);
        chk("irq_b_flag",  32'(bus.b_flag),  32'd0);
        tick();
        bus.vec_fetch = 1'b0; bus.vec_done = 1'b1; IRQ = 1'b1;
        tick();
        idle_inputs();
        ticks(3);

        // BRK with IRQ masked
        IRQ = 1'b0; bus.p_i = 1'b1;
        ticks(3);
        bus.sync = 1'b1; bus.brk_op = 1'b1;
        #1;
        chk("brk_sync_force_brk", 32'(bus.force_brk), 32'd0);
        tick();
        bus.sync = 1'b0; bus.brk_op = 1'b0;
        #1;
        chk("brk_force_brk", 32'(bus.force_brk),   32'd0);
        chk("brk_ipc",       32'(bus.ipc_inhibit), 32'd0);
        chk("brk_b_flag",    32'(bus.b_flag),      32'd1);
        tick();
        bus.vec_fetch = 1'b1;
        #1;
        chk("brk_vec_adl", 32'(bus.vec_adl), 32'hFE);
        tick();
        bus.vec_fetch = 1'b0; bus.vec_done = 1'b1; IRQ = 1'b1;
        tick();
        idle_inputs();
        ticks(3);

        // NMI hijacks a BRK, then held low gives no second service
        bus.sync = 1'b1; bus.brk_op = 1'b1;
        tick();
        bus.sync = 1'b0; bus.brk_op = 1'b0; NMI = 1'b0;
        ticks(3);
        bus.vec_fetch = 1'b1;
        #1;
        chk("hijack_vec_adl",  32'(bus.vec_adl),  32'hFA);
        chk("hijack_nmi_pend", 32'(bus.nmi_pend), 32'd1);
        tick();
        bus.vec_fetch = 1'b0; bus.vec_done = 1'b1;
        #1;
        chk("hijack_pend_clr", 32'(bus.nmi_pend), 32'd0);
        tick();
        idle_inputs(); bus.sync = 1'b1;
        for (int k = 0; k < 6; k++) begin
            #1;
            chk("nmi_held_no_retake", 32'(bus.force_brk), 32'd0);
            tick();
        end
        idle_inputs(); NMI = 1'b1;
        ticks(3);

        // NMI edge coincident with the $FFFA fetch
        NMI = 1'b0; tick();
        NMI = 1'b1; ticks(2);
        bus.sync = 1'b1;
        #1;
        chk("nmi_take", 32'(bus.force_brk), 32'd1);
        tick();
        bus.sync = 1'b0; NMI = 1'b0;
        ticks(2);
        bus.vec_fetch = 1'b1;
        #1;
        chk("coinc_vec_adl", 32'(bus.vec_adl), 32'hFA);
        tick();
        bus.vec_fetch = 1'b0; bus.vec_done = 1'b1;
        #1;
        chk("coinc_pend_kept", 32'(bus.nmi_pend), 32'd1);
        tick();
        bus.vec_done = 1'b0; bus.sync = 1'b1;
        #1;
        chk("coinc_retake", 32'(bus.force_brk), 32'd1);
        tick();
        bus.sync = 1'b0; bus.vec_fetch = 1'b1;
        #1;
        chk("coinc_vec2", 32'(bus.vec_adl), 32'hFA);
        tick();
        bus.vec_fetch = 1'b0; bus.vec_done = 1'b1;
        tick();
        idle_inputs(); NMI = 1'b1;
        ticks(3);

        // READY stall during IRQ service with an NMI pulse
        IRQ = 1'b0; bus.p_i = 1'b0;
        ticks(3);
        bus.sync = 1'b1;
        tick();
        bus.sync = 1'b0; IRQ = 1'b1; bus.p_i = 1'b1;
        bus.READY = 1'b0; bus.vec_done = 1'b1;
        for (int k = 0; k < 5; k++) begin
            NMI = (k == 0) ? 1'b0 : 1'b1;
            #1;
            chk("stall_hold_force_brk", 32'(bus.force_brk), 32'd1);
            if (k >= 3) chk("stall_nmi_pend", 32'(bus.nmi_pend), 32'd1);
            tick();
        end
        idle_inputs(); bus.vec_fetch = 1'b1;
        #1;
        chk("stall_vec_adl", 32'(bus.vec_adl), 32'hFA);
        tick();
        bus.vec_fetch = 1'b0; bus.vec_done = 1'b1;
        tick();
        idle_inputs();
        ticks(3);

        // random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            i_rst         = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) NMI = ~NMI;
            if ($urandom_range(0, 5) == 0) IRQ = ~IRQ;
            if ($urandom_range(0, 9) == 0) bus.p_i = ~bus.p_i;
            bus.READY     = ($urandom_range(0, 4) != 0);
            bus.sync      = ($urandom_range(0, 3) == 0);
            bus.brk_op    = ($urandom_range(0, 2) == 0);
            bus.vec_fetch = ($urandom_range(0, 3) == 0);
            bus.vec_done  = ($urandom_range(0, 4) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/irq_sequencer.md
IRQ_SEQUENCER -- requirements
Module: irq_sequencer

Interface
REQ-001 SHALL have port i_clk, input, 1: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port NMI, input, 1: active-low non-maskable interrupt pin, asynchronous to i_clk.
REQ-004 SHALL have port IRQ, input, 1: active-low maskable interrupt pin, asynchronous to i_clk.
REQ-005 SHALL have port READY, input, 1: high = core advances this cycle; low = all sequencer state holds.
REQ-006 SHALL have port sync, input, 1: decode is in the opcode-fetch cycle (instruction boundary).
REQ-007 SHALL have port p_i, input, 1: processor status I flag (1 = IRQ masked).
REQ-008 SHALL have port brk_op, input, 1: opcode being fetched this sync cycle is BRK.
REQ-009 SHALL have port vec_fetch, input, 1: decode is driving the vector low byte onto ADL this cycle.
REQ-010 SHALL have port vec_done, input, 1: decode has finished loading the vector high byte into PCH.
REQ-011 SHALL have port force_brk, output, 1: decode loads 8'h00 into IR instead of din.
REQ-012 SHALL have port ipc_inhibit, output, 1: suppress PC increment (IPC).
REQ-013 SHALL have port rw_inhibit, output, 1: force RW to read (reset stack cycles).
REQ-014 SHALL have port vec_adl, output, 8: vector low byte, 8'hFA NMI, 8'hFC RESET, 8'hFE IRQ/BRK.
REQ-015 SHALL have port b_flag, output, 1: B bit value for the pushed status byte.
REQ-016 SHALL have port nmi_pend, output, 1: NMI edge latched, not yet serviced.

Function
REQ-017 SHALL pass NMI and IRQ each through a two-flop synchronizer; sampled values are called nmi_s and irq_s.
REQ-018 SHALL set nmi_pend on a 1->0 transition of nmi_s (edge-sensitive; a held-low NMI produces exactly one edge).
REQ-019 SHALL treat irq_req = !irq_s & !p_i as level-sensitive and not latch it.
REQ-020 SHALL implement FSM states ST_RST, ST_RUN and ST_INT.
REQ-021 ST_RST SHALL drive force_brk=1, ipc_inhibit=1, rw_inhibit=1, b_flag=0 and vec_adl=8'hFC, and SHALL go to ST_RUN on vec_done.
REQ-022 In ST_RUN, on sync&READY with nmi_pend|irq_req, the FSM SHALL go to ST_INT, assert force_brk and ipc_inhibit combinationally in that same cycle, and register int_kind (NMI if nmi_pend, else IRQ).
REQ-023 In ST_RUN, on sync&READY with brk_op and no interrupt, the FSM SHALL register int_kind=BRK and go to ST_INT; force_brk and ipc_inhibit stay 0.
REQ-024 ST_INT SHALL hold force_brk and ipc_inhibit at 1 for NMI/IRQ kinds and at 0 for BRK; b_flag SHALL be 1 only for BRK.
REQ-025 ST_INT SHALL select vec_adl at vec_fetch: 8'hFA if nmi_pend, else 8'hFE; an NMI arriving before vec_fetch therefore hijacks a BRK or IRQ.
REQ-026 The FSM SHALL clear nmi_pend in the cycle vec_fetch selects 8'hFA; a new NMI edge in that same cycle SHALL leave nmi_pend set.
REQ-027 ST_INT SHALL return to ST_RUN on vec_done.
REQ-028 Deassertion of IRQ or a change of p_i after entry to ST_INT SHALL NOT abort the service.
REQ-029 With READY=0 the FSM, nmi_pend and int_kind SHALL hold; the synchronizers and edge detector keep running, and an edge seen while READY=0 SHALL still set nmi_pend.
REQ-030 Outside ST_RST/ST_INT all outputs SHALL be 0 except nmi_pend and vec_adl, and vec_adl SHALL read 8'hFE.

Reset
REQ-031 On i_rst the block SHALL set state=ST_RST, nmi_pend=0, synchronizer flops=1 and edge history=1; outputs then read force_brk=1, ipc_inhibit=1, rw_inhibit=1, vec_adl=8'hFC, b_flag=0, nmi_pend=0.
REQ-032 i_rst asserted in ST_INT SHALL abandon the service immediately; the latched NMI SHALL be lost.

Structure
REQ-033 A shared package cpu6502_pkg SHALL hold the vector constants VEC_NMI=8'hFA, VEC_RST=8'hFC and VEC_IRQ=8'hFE, the state enum and the int_kind enum.
REQ-034 The synchronizer SHALL be a separate sub-module sync2 (two flops, reset value parameterised), instantiated twice.

Verification
REQ-035 The bench SHALL check: i_rst for 2 cycles, then vec_fetch -> vec_adl=8'hFC and rw_inhibit=1; vec_done -> ST_RUN and all inhibits 0.
REQ-036 The bench SHALL check: IRQ low, p_i=0, then sync -> force_brk=1 and ipc_inhibit=1 that cycle; vec_adl=8'hFE at vec_fetch; b_flag=0.
REQ-037 The bench SHALL check: IRQ low, p_i=1, brk_op at sync -> force_brk=0, b_flag=1, vec_adl=8'hFE.
REQ-038 The bench SHALL check: BRK service started, NMI falls 3 cycles before vec_fetch -> vec_adl=8'hFA and nmi_pend cleared; with NMI held low there SHALL be no second service.
REQ-039 The bench SHALL check: NMI edge coincident with the 8'hFA vec_fetch -> nmi_pend stays 1 and the next sync enters NMI service again.
REQ-040 The bench SHALL check: READY=0 for 5 cycles during ST_INT with NMI pulsed -> state holds, nmi_pend=1 after the pulse is synchronized.
